simd_regfile_stop_rx: RTL and testbench
=======================================

SIMD_REGFILE_STOP_RX -- requirements
Module: simd_regfile_stop_rx

Interface
REQ-001 Parameters: NUM_REGS, default 10, number of configuration registers.
REQ-002 Parameters: DATA_W, default 32, width of each register.
REQ-003 Parameters: ADDR_W, default 4, width of the register address.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset_poweron  in  1  asynchronous, active-low reset.
REQ-006 Port: peId  in  8  PE identifier; echoed on cfg_peid.
REQ-007 Port: simd__scntl__valid  in  1  SIMD register-write beat valid.
REQ-008 Port: simd__scntl__addr  in  ADDR_W  target register index.
REQ-009 Port: simd__scntl__data  in  DATA_W  write data.
REQ-010 Port: simd__scntl__last  in  1  beat completes a configuration set and requests commit.
REQ-011 Port: scntl__simd__ready  out  1  beat accepted when valid and ready are both 1.
REQ-012 Port: scntl__simd__err  out  1  sticky out-of-range address flag.
REQ-013 Port: scntl__stop__cfg_valid  out  1  active configuration pending for stOp.
REQ-014 Port: stop__scntl__cfg_ready  in  1  stOp consumes the active configuration.
REQ-015 Port: scntl__stop__cfg_bus  out  NUM_REGS*DATA_W  active bank; register i occupies bits [i*DATA_W +: DATA_W].
REQ-016 Port: scntl__stop__cfg_tag  out  8  commit sequence number of the active bank.
REQ-017 Port: scntl__stop__cfg_peid  out  8  registered copy of peId, captured at commit.

Function
REQ-018 Storage SHALL be double-buffered: a shadow bank written by SIMD beats, and an active bank driven on cfg_bus.
REQ-019 FSM states SHALL be IDLE, LOAD and HOLD.
REQ-020 The ready output SHALL be 1 in IDLE and LOAD and 0 in HOLD.
REQ-021 An accepted beat with addr < NUM_REGS SHALL write shadow[addr] at the next edge.
REQ-022 An accepted beat with addr >= NUM_REGS SHALL be dropped and SHALL set err; err SHALL clear only on reset. A last flag on a dropped beat still applies.
REQ-023 Unwritten shadow registers SHALL retain their previous values across commits.
REQ-024 IDLE: an accepted beat without last SHALL go to LOAD.
REQ-025 IDLE or LOAD: an accepted beat with last SHALL commit when the active bank is free; otherwise the FSM SHALL go to HOLD.
REQ-026 The active bank is free when cfg_valid=0, or when cfg_valid=1 and cfg_ready=1 in the same cycle.
REQ-027 A commit from IDLE or LOAD SHALL return the FSM to IDLE.
REQ-028 Commit: at the next edge, the active bank SHALL be loaded with the shadow contents, with the committing beat's write merged in.
REQ-029 Commit: at the same edge, cfg_valid SHALL become 1, cfg_tag SHALL increment modulo 256, and cfg_peid SHALL capture peId.
REQ-030 Commit latency: last beat accepted at edge N -> new cfg_bus and cfg_valid=1 visible after edge N.
REQ-031 HOLD: when cfg_ready=1, a commit SHALL occur at that edge and the FSM SHALL go to IDLE; no beat is accepted in that cycle.
REQ-032 A cfg handshake (cfg_valid and cfg_ready both 1) with no simultaneous commit SHALL clear cfg_valid at the next edge.
REQ-033 A handshake with a simultaneous commit SHALL keep cfg_valid=1 with the new contents.
REQ-034 cfg_bus and cfg_tag SHALL be stable while cfg_valid=1 and cfg_ready=0.
REQ-035 Inputs SHALL be ignored while valid=0; the last input is meaningful only on an accepted beat.

Reset
REQ-036 Reset assertion (reset_poweron=0) SHALL asynchronously force: FSM to IDLE, both banks to 0, cfg_valid 0, cfg_tag 0, cfg_peid 0, err 0.
REQ-037 Ready SHALL be 0 while reset is asserted and 1 from the first edge after deassertion.
REQ-038 Reset mid-LOAD or mid-HOLD SHALL discard all partial shadow writes; no commit SHALL occur.

Verification
REQ-039 Write addr 0..9 with data 0x100+i, last on addr 9 -> one cycle later cfg_valid=1, cfg_tag=1, register 3 reads 0x103.
REQ-040 Hold cfg_ready=0, then send a second set with last -> FSM enters HOLD, ready=0, cfg_bus unchanged. Then pulse cfg_ready=1 -> cfg_tag=2, cfg_valid stays 1, new data visible, ready=1 again.
REQ-041 Send a beat with addr=12 followed by a last beat to addr 0 -> err=1, registers 1..9 unchanged, register 0 updated.
REQ-042 With cfg_valid=1, cfg_ready=1 and no commit -> cfg_valid=0 next cycle. With cfg_ready=1 and a simultaneous last beat -> cfg_valid stays 1 and the tag increments.
REQ-043 Perform 256 commits -> cfg_tag wraps from 0xFF to 0x00.
REQ-044 Assert reset during LOAD after 3 beats -> all outputs 0. A subsequent single last beat to addr 2 -> register 2 set, all other registers 0, cfg_tag=1.

Source files
------------

// File: rtl/simd_regfile_stop_rx.sv
// Double-buffered SIMD configuration register file feeding the stOp stage.
// SIMD beats fill a shadow bank; a beat flagged "last" commits the shadow
// bank (with that beat merged in) to the active bank. If the active bank is
// still owned by stOp, the commit waits in HOLD until stOp consumes it.
module simd_regfile_stop_rx #(
  parameter int NUM_REGS = 10,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic [7:0]                 peId,
  input  logic                       simd__scntl__valid,
  input  logic [ADDR_W-1:0]          simd__scntl__addr,
  input  logic [DATA_W-1:0]          simd__scntl__data,
  input  logic                       simd__scntl__last,
  output logic                       scntl__simd__ready,
  output logic                       scntl__simd__err,
  output logic                       scntl__stop__cfg_valid,
  input  logic                       stop__scntl__cfg_ready,
  output logic [NUM_REGS*DATA_W-1:0] scntl__stop__cfg_bus,
  output logic [7:0]                 scntl__stop__cfg_tag,
  output logic [7:0]                 scntl__stop__cfg_peid
);

  // state | meaning
  // IDLE  | no partial set in the shadow bank, beats accepted
  // LOAD  | partial set being written, beats accepted
  // HOLD  | last beat seen, waiting for stOp to release the active bank
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  state_t              state_q, state_d;
  logic                ready_q;
  logic                cfg_valid_q;
  logic [7:0]          tag_q;
  logic [7:0]          peid_q;
  logic                err_q;
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];
  logic [DATA_W-1:0]   active_q [NUM_REGS];

  logic accept;
  logic in_range;
  logic bank_free;
  logic commit;

  // Beat acceptance, shadow merge, and commit/next-state decisions.
  always_comb begin
    accept    = simd__scntl__valid & ready_q;
    in_range  = ({1'b0, simd__scntl__addr} < NUM_REGS_W);
    bank_free = ~cfg_valid_q | stop__scntl__cfg_ready;

    shadow_d = shadow_q;
    if (accept && in_range) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (simd__scntl__addr == ADDR_W'(i)) shadow_d[i] = simd__scntl__data;
      end
    end

    commit  = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (simd__scntl__last) begin
            if (bank_free) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else begin
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        if (stop__scntl__cfg_ready) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      tag_q       <= 8'd0;
      peid_q      <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != HOLD);
      if (accept && !in_range) err_q <= 1'b1;
      if (commit) begin
        cfg_valid_q <= 1'b1;
        tag_q       <= tag_q + 8'd1;
        peid_q      <= peId;
      end else if (cfg_valid_q && stop__scntl__cfg_ready) begin
        cfg_valid_q <= 1'b0;
      end
    end
  end

  // Shadow bank tracks every accepted write; active bank loads on commit.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      if (commit) active_q <= shadow_d;
    end
  end

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_bus
    assign scntl__stop__cfg_bus[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign scntl__simd__ready     = ready_q;
  assign scntl__simd__err       = err_q;
  assign scntl__stop__cfg_valid = cfg_valid_q;
  assign scntl__stop__cfg_tag   = tag_q;
  assign scntl__stop__cfg_peid  = peid_q;

endmodule

// File: tb/tb_simd_regfile_stop_rx.sv
// Directed bench for simd_regfile_stop_rx with hand-computed expectations.
module tb_simd_regfile_stop_rx;

  localparam int NUM_REGS = 10;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int BUS_W    = NUM_REGS*DATA_W;

  logic              clk = 1'b0;
  logic              reset_poweron;
  logic [7:0]        peId;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;
  logic              err;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [BUS_W-1:0]  cfg_bus;
  logic [7:0]        cfg_tag;
  logic [7:0]        cfg_peid;

  int checks   = 0;
  int failures = 0;
  logic [BUS_W-1:0] exp_bus;

  simd_regfile_stop_rx #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset_poweron          (reset_poweron),
    .peId                   (peId),
    .simd__scntl__valid     (valid),
    .simd__scntl__addr      (addr),
    .simd__scntl__data      (data),
    .simd__scntl__last      (last),
    .scntl__simd__ready     (ready),
    .scntl__simd__err       (err),
    .scntl__stop__cfg_valid (cfg_valid),
    .stop__scntl__cfg_ready (cfg_ready),
    .scntl__stop__cfg_bus   (cfg_bus),
    .scntl__stop__cfg_tag   (cfg_tag),
    .scntl__stop__cfg_peid  (cfg_peid)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] reg_of(int i);
    return cfg_bus[i*DATA_W +: DATA_W];
  endfunction

  task automatic check(string tag, logic [BUS_W-1:0] obs, logic [BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a single cycle (caller ensures ready=1).
  task automatic beat(int a, logic [DATA_W-1:0] d, logic l);
    valid = 1'b1;
    addr  = ADDR_W'(a);
    data  = d;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  initial begin
    reset_poweron = 1'b0;
    peId = 8'h00; valid = 1'b0; addr = '0; data = '0; last = 1'b0; cfg_ready = 1'b0;
    tick(); tick();
    check("rst_ready", BUS_W'(ready), BUS_W'(0));
    check("rst_valid", BUS_W'(cfg_valid), BUS_W'(0));
    check("rst_tag", BUS_W'(cfg_tag), BUS_W'(0));
    check("rst_err", BUS_W'(err), BUS_W'(0));
    check("rst_bus", cfg_bus, '0);
    reset_poweron = 1'b1;
    #1;
    check("ready_before_edge", BUS_W'(ready), BUS_W'(0));
    tick();
    check("ready_after_edge", BUS_W'(ready), BUS_W'(1));

    // First full set, committed immediately.
    peId = 8'h5A;
    for (int i = 0; i < 9; i++) beat(i, 32'h100 + i, 1'b0);
    check("valid_before_last", BUS_W'(cfg_valid), BUS_W'(0));
    beat(9, 32'h109, 1'b1);
    check("set1_valid", BUS_W'(cfg_valid), BUS_W'(1));
    check("set1_tag", BUS_W'(cfg_tag), BUS_W'(1));
    check("set1_reg3", BUS_W'(reg_of(3)), BUS_W'(32'h103));
    check("set1_reg9", BUS_W'(reg_of(9)), BUS_W'(32'h109));
    check("set1_peid", BUS_W'(cfg_peid), BUS_W'(8'h5A));

    // Second set while stOp holds the bank: HOLD then release.
    peId = 8'h33;
    for (int i = 0; i < 10; i++) beat(i, 32'h200 + i, i == 9);
    check("hold_ready", BUS_W'(ready), BUS_W'(0));
    check("hold_reg3", BUS_W'(reg_of(3)), BUS_W'(32'h103));
    check("hold_tag", BUS_W'(cfg_tag), BUS_W'(1));
    tick();
    check("hold_stay_ready", BUS_W'(ready), BUS_W'(0));
    check("hold_stay_valid", BUS_W'(cfg_valid), BUS_W'(1));
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("rel_tag", BUS_W'(cfg_tag), BUS_W'(2));
    check("rel_valid", BUS_W'(cfg_valid), BUS_W'(1));
    check("rel_reg3", BUS_W'(reg_of(3)), BUS_W'(32'h203));
    check("rel_peid", BUS_W'(cfg_peid), BUS_W'(8'h33));
    check("rel_ready", BUS_W'(ready), BUS_W'(1));

    // Handshake without commit clears valid; contents stay.
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
    check("hs_valid_clear", BUS_W'(cfg_valid), BUS_W'(0));
    check("hs_tag_same", BUS_W'(cfg_tag), BUS_W'(2));

    // last without valid is ignored.
    last = 1'b1;
    tick();
    last = 1'b0;
    check("idle_last_ignored", BUS_W'(cfg_tag), BUS_W'(2));

    beat(5, 32'h555, 1'b1);
    check("c3_tag", BUS_W'(cfg_tag), BUS_W'(3));
    check("c3_valid", BUS_W'(cfg_valid), BUS_W'(1));
    cfg_ready = 1'b1;
    beat(6, 32'h666, 1'b1);
    check("hs_commit_valid", BUS_W'(cfg_valid), BUS_W'(1));
    check("hs_commit_tag", BUS_W'(cfg_tag), BUS_W'(4));
    check("hs_commit_reg6", BUS_W'(reg_of(6)), BUS_W'(32'h666));
    check("hs_commit_reg5", BUS_W'(reg_of(5)), BUS_W'(32'h555));

    // Out-of-range beat dropped, sticky err, then last to addr 0.
    cfg_ready = 1'b0;
    beat(12, 32'hDEAD, 1'b0);
    check("err_set", BUS_W'(err), BUS_W'(1));
    check("err_no_commit", BUS_W'(cfg_tag), BUS_W'(4));
    cfg_ready = 1'b1;
    beat(0, 32'hABC, 1'b1);
    check("oor_tag", BUS_W'(cfg_tag), BUS_W'(5));
    exp_bus = '0;
    exp_bus[0*DATA_W +: DATA_W] = 32'hABC;
    for (int i = 1; i < 10; i++) exp_bus[i*DATA_W +: DATA_W] = 32'h200 + i;
    exp_bus[5*DATA_W +: DATA_W] = 32'h555;
    exp_bus[6*DATA_W +: DATA_W] = 32'h666;
    check("oor_bus", cfg_bus, exp_bus);
    check("err_sticky", BUS_W'(err), BUS_W'(1));

    // Tag wrap: 250 more commits reach 0xFF, one more wraps to 0x00.
    for (int k = 0; k < 250; k++) beat(1, 32'(k), 1'b1);
    check("tag_ff", BUS_W'(cfg_tag), BUS_W'(8'hFF));
    beat(1, 32'h777, 1'b1);
    check("tag_wrap", BUS_W'(cfg_tag), BUS_W'(8'h00));
    check("wrap_reg1", BUS_W'(reg_of(1)), BUS_W'(32'h777));
    cfg_ready = 1'b0;

    // Reset mid-LOAD discards everything.
    beat(0, 32'hA0, 1'b0);
    beat(1, 32'hA1, 1'b0);
    beat(2, 32'hA2, 1'b0);
    reset_poweron = 1'b0;
    #2;
    check("mid_rst_bus", cfg_bus, '0);
    check("mid_rst_valid", BUS_W'(cfg_valid), BUS_W'(0));
    check("mid_rst_tag", BUS_W'(cfg_tag), BUS_W'(0));
    check("mid_rst_err", BUS_W'(err), BUS_W'(0));
    check("mid_rst_peid", BUS_W'(cfg_peid), BUS_W'(0));
    check("mid_rst_ready", BUS_W'(ready), BUS_W'(0));
    tick();
    reset_poweron = 1'b1;
    tick();
    check("post_rst_ready", BUS_W'(ready), BUS_W'(1));
    beat(2, 32'h22, 1'b1);
    exp_bus = '0;
    exp_bus[2*DATA_W +: DATA_W] = 32'h22;
    check("post_rst_bus", cfg_bus, exp_bus);
    check("post_rst_tag", BUS_W'(cfg_tag), BUS_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
